// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a
// load/store port, sequencing each grant through ACCESS/HOLD/RESP.
module mem_arbiter #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_addr,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_q,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, RESP} state_e;

  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        sel_data;
  logic        sel_we;
  logic [31:0] sel_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_F;
      last_q      <= GRANT_D;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    err_d       = err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // On a tie the port that was not served last wins.
    sel_data    = d_req && (!if_req || (last_q == GRANT_F));
    sel_we      = sel_data && d_we;
    sel_addr    = sel_data ? d_addr : if_addr;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant_d = sel_data;
          we_d    = sel_we;
          if (sel_addr < 32'(DEPTH)) begin
            err_d       = 1'b0;
            state_d     = ACCESS;
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_we ? d_wdata : 32'h0;
          end else begin
            // Rejected reads skip the memory and return zero data.
            err_d   = 1'b1;
            state_d = RESP;
            if (!sel_we) begin
              if (sel_data) d_rdata_d  = 32'h0;
              else          if_rdata_d = 32'h0;
            end
          end
        end
      end
      ACCESS: state_d = HOLD;
      HOLD: begin
        if (!we_q) begin
          if (grant_q == GRANT_D) d_rdata_d  = ram_q;
          else                    if_rdata_d = ram_q;
        end
        state_d = RESP;
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_ack    = (state_q == RESP) && (grant_q == GRANT_F);
  assign d_ack     = (state_q == RESP) && (grant_q == GRANT_D);
  assign if_err    = if_ack && err_q;
  assign d_err     = d_ack && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_read  = (state_q == ACCESS) && !we_q;
  assign ram_write = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_q;
  logic        ram_read, ram_write, busy;

  logic [31:0] mem [0:511];
  logic        preWe = 1'b0;
  logic [8:0]  preAddr = '0;
  logic [31:0] preData = '0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } expT;

  expT sb[$];
  int  compared = 0;
  int  mismatched = 0;
  logic [31:0] dModel = 32'h0;

  mem_arbiter #(.DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_read)  ram_q <= mem[ram_addr[8:0]];
    if (ram_write) mem[ram_addr[8:0]] <= ram_wdata;
    if (preWe)     mem[preAddr] <= preData;
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] v);
    @(negedge clk); preWe = 1'b1; preAddr = a; preData = v;
    @(negedge clk); preWe = 1'b0;
  endtask

  // Issues one request and records what the DUT did; comparisons live in the callers.
  task automatic doReq(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int ackCyc, output logic ackPort,
                       output logic [31:0] rdata, output logic err, output int rdCnt,
                       output int wrCnt, output int badCnt, output logic [15:0] rdMask);
    ackCyc = -1; ackPort = 1'b0; rdata = '0; err = 1'b0;
    rdCnt = 0; wrCnt = 0; badCnt = 0; rdMask = '0;
    @(negedge clk);
    if (port) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    for (int c = 1; c <= 12; c++) begin
      if (ackCyc < 0) begin
        @(negedge clk);
        if (ram_read) begin rdCnt++; rdMask[c] = 1'b1; end
        if (ram_write) wrCnt++;
        if ((ram_read && ram_write) || ((ram_read || ram_write) && ram_addr >= 32'd512)) badCnt++;
        if (if_ack || d_ack) begin
          ackCyc = c; ackPort = d_ack;
          rdata = d_ack ? d_rdata : if_rdata;
          err = d_ack ? d_err : if_err;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] obs [11];
    string nm [11];
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nm  = '{"if_ack", "d_ack", "if_err", "d_err", "busy", "if_rdata", "d_rdata",
            "ram_addr", "ram_wdata", "ram_read", "ram_write"};
    obs = '{32'(if_ack), 32'(d_ack), 32'(if_err), 32'(d_err), 32'(busy), if_rdata, d_rdata,
            ram_addr, ram_wdata, 32'(ram_read), 32'(ram_write)};
    for (int i = 0; i < 11; i++) begin
      compared++;
      if (obs[i] !== 32'h0) begin
        mismatched++; $display("[TB] FAIL reset_%s: got %h want 0", nm[i], obs[i]);
      end
    end
  endtask

  task automatic test_fetch;
    int ackCyc, rdCnt, wrCnt, badCnt; logic ackPort, err; logic [31:0] rdata; logic [15:0] mask;
    expT e;
    preload(9'h000, 32'hB9800000);
    sb.push_back('{1'b0, 32'hB9800000, 1'b0});
    doReq(1'b0, 1'b0, 32'h0, 32'h0, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    compared++; if (ackCyc !== 3) begin mismatched++; $display("[TB] FAIL fetch_latency: got %0d want 3", ackCyc); end
    compared++; if (ackPort !== e.port) begin mismatched++; $display("[TB] FAIL fetch_port: got %b want %b", ackPort, e.port); end
    compared++; if (rdata !== e.rdata) begin mismatched++; $display("[TB] FAIL fetch_rdata: got %h want %h", rdata, e.rdata); end
    compared++; if (err !== e.err) begin mismatched++; $display("[TB] FAIL fetch_err: got %b want %b", err, e.err); end
    compared++; if (mask !== 16'h0002) begin mismatched++; $display("[TB] FAIL fetch_read_cycles: got %h want 0002", mask); end
    compared++; if (badCnt !== 0 || wrCnt !== 0) begin mismatched++; $display("[TB] FAIL fetch_strobes: bad %0d wr %0d want 0 0", badCnt, wrCnt); end
  endtask

  task automatic test_store_load;
    int ackCyc, rdCnt, wrCnt, badCnt; logic ackPort, err; logic [31:0] rdata; logic [15:0] mask;
    expT e;
    sb.push_back('{1'b1, dModel, 1'b0});
    doReq(1'b1, 1'b1, 32'h87, 32'h12345678, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    compared++; if (ackCyc !== 3 || ackPort !== e.port) begin mismatched++; $display("[TB] FAIL store_ack: cyc %0d port %b want 3 %b", ackCyc, ackPort, e.port); end
    compared++; if (rdata !== e.rdata) begin mismatched++; $display("[TB] FAIL store_rdata_kept: got %h want %h", rdata, e.rdata); end
    compared++; if (wrCnt !== 1 || rdCnt !== 0) begin mismatched++; $display("[TB] FAIL store_strobes: wr %0d rd %0d want 1 0", wrCnt, rdCnt); end
    compared++; if (mem[9'h087] !== 32'h12345678) begin mismatched++; $display("[TB] FAIL store_mem: got %h want 12345678", mem[9'h087]); end
    dModel = 32'h12345678;
    sb.push_back('{1'b1, dModel, 1'b0});
    doReq(1'b1, 1'b0, 32'h87, 32'h0, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    compared++; if (ackCyc !== 3 || ackPort !== e.port || err !== e.err) begin mismatched++; $display("[TB] FAIL load_ack: cyc %0d port %b err %b want 3 %b %b", ackCyc, ackPort, err, e.port, e.err); end
    compared++; if (rdata !== e.rdata) begin mismatched++; $display("[TB] FAIL load_rdata: got %h want %h", rdata, e.rdata); end
  endtask

  task automatic test_round_robin;
    int acks = 0, lastAck = 0, both = 0, fDone = 0, dDone = 0;
    logic fPend = 1'b0, dPend = 1'b0;
    expT e;
    preload(9'h010, 32'hF0000010); preload(9'h011, 32'hF0000011);
    preload(9'h020, 32'hD0000020); preload(9'h021, 32'hD0000021);
    sb.push_back('{1'b0, 32'hF0000010, 1'b0}); sb.push_back('{1'b1, 32'hD0000020, 1'b0});
    sb.push_back('{1'b0, 32'hF0000011, 1'b0}); sb.push_back('{1'b1, 32'hD0000021, 1'b0});
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 1; c <= 40; c++) begin
      if (acks < 4) begin
        @(negedge clk);
        if (fPend) begin if_req = 1'b1; if_addr = 32'h11; fPend = 1'b0; end
        if (dPend) begin d_req = 1'b1; d_addr = 32'h21; dPend = 1'b0; end
        if (ram_read && ram_write) both++;
        if ((if_ack || d_ack) && sb.size() > 0) begin
          e = sb.pop_front();
          compared++; if (d_ack !== e.port) begin mismatched++; $display("[TB] FAIL rr_order_%0d: got port %b want %b", acks, d_ack, e.port); end
          compared++; if ((d_ack ? d_rdata : if_rdata) !== e.rdata) begin mismatched++; $display("[TB] FAIL rr_rdata_%0d: got %h want %h", acks, d_ack ? d_rdata : if_rdata, e.rdata); end
          compared++; if (c - lastAck !== (acks == 0 ? 3 : 4)) begin mismatched++; $display("[TB] FAIL rr_spacing_%0d: got %0d want %0d", acks, c - lastAck, acks == 0 ? 3 : 4); end
          lastAck = c; acks++;
          if (if_ack) begin if_req = 1'b0; fDone++; fPend = (fDone < 2); end
          if (d_ack)  begin d_req = 1'b0; dDone++; dPend = (dDone < 2); end
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    dModel = 32'hD0000021;
    compared++; if (acks !== 4) begin mismatched++; $display("[TB] FAIL rr_timeout: got %0d acks want 4", acks); end
    compared++; if (both !== 0) begin mismatched++; $display("[TB] FAIL rr_strobe_overlap: got %0d want 0", both); end
  endtask

  task automatic test_error;
    int ackCyc, rdCnt, wrCnt, badCnt; logic ackPort, err; logic [31:0] rdata; logic [15:0] mask;
    expT e;
    sb.push_back('{1'b1, 32'h0, 1'b1});
    doReq(1'b1, 1'b0, 32'd512, 32'h0, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    dModel = 32'h0;
    compared++; if (ackCyc !== 1 || ackPort !== e.port) begin mismatched++; $display("[TB] FAIL err_latency: cyc %0d port %b want 1 %b", ackCyc, ackPort, e.port); end
    compared++; if (err !== e.err) begin mismatched++; $display("[TB] FAIL err_flag: got %b want %b", err, e.err); end
    compared++; if (rdata !== e.rdata) begin mismatched++; $display("[TB] FAIL err_rdata: got %h want %h", rdata, e.rdata); end
    compared++; if (rdCnt !== 0 || wrCnt !== 0) begin mismatched++; $display("[TB] FAIL err_strobes: rd %0d wr %0d want 0 0", rdCnt, wrCnt); end
    preload(9'h1FF, 32'h5A5A1FF0);
    sb.push_back('{1'b0, 32'h5A5A1FF0, 1'b0});
    doReq(1'b0, 1'b0, 32'd511, 32'h0, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    compared++; if (ackCyc !== 3 || err !== e.err || rdata !== e.rdata) begin mismatched++; $display("[TB] FAIL edge511: cyc %0d err %b data %h want 3 %b %h", ackCyc, err, rdata, e.err, e.rdata); end
  endtask

  task automatic test_reset_midop;
    int ackCyc, rdCnt, wrCnt, badCnt; logic ackPort, err; logic [31:0] rdata; logic [15:0] mask;
    logic ackSeen = 1'b0;
    expT e;
    preload(9'h095, 32'hAAAAAAAA);
    @(negedge clk); if_req = 1'b1; if_addr = 32'h95;
    @(negedge clk); ackSeen |= if_ack;
    @(negedge clk); ackSeen |= if_ack; reset = 1'b1;
    @(negedge clk);
    ackSeen |= if_ack;
    compared++; if (ackSeen !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_ack: got %b want 0", ackSeen); end
    compared++;
    if ({busy, ram_read, ram_write, if_ack, if_err} !== 5'b0 || if_rdata !== 32'h0 || ram_addr !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midop_outputs: busy %b rd %b wr %b ack %b rdata %h addr %h want all 0",
               busy, ram_read, ram_write, if_ack, if_rdata, ram_addr);
    end
    if_req = 1'b0; reset = 1'b0;
    sb.push_back('{1'b0, 32'hAAAAAAAA, 1'b0});
    doReq(1'b0, 1'b0, 32'h95, 32'h0, ackCyc, ackPort, rdata, err, rdCnt, wrCnt, badCnt, mask);
    e = sb.pop_front();
    compared++; if (ackCyc !== 3 || rdata !== e.rdata || ackPort !== e.port) begin mismatched++; $display("[TB] FAIL midop_refetch: cyc %0d data %h want 3 %h", ackCyc, rdata, e.rdata); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_round_robin();
    test_error();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
